// File: rtl/fb_sched_pkg.sv
// Shared types and constants for the framebuffer scan-out scheduler.
package fb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ISSUE      = 2'd2,
    DRAIN      = 2'd3
  } sched_state_t;

  localparam int unsigned FB_ADDR_W         = 22;
  localparam int unsigned FB_DEFAULT_CHUNKS = 115200;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fb_credit_counter.sv
// Up/down credit counter: simultaneous inc/dec cancel, decrement ignored at zero,
// increment ignored at MAX_COUNT unless a decrement happens in the same cycle.
module fb_credit_counter #(
  parameter int unsigned MAX_COUNT = 16,
  parameter int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count_out,
  output logic [CNT_W-1:0] count_next_out,
  output logic             full_out,
  output logic             empty_out
);
  import fb_sched_pkg::*;

  logic [CNT_W-1:0] count_q, count_d;
  logic             inc_ok_s, dec_ok_s;

  // Next count with underflow/overflow guards
  always_comb begin
    count_d  = count_q;
    dec_ok_s = dec & (count_q != {CNT_W{1'b0}});
    inc_ok_s = inc & ((count_q != CNT_W'(MAX_COUNT)) | dec_ok_s);
    case ({inc_ok_s, dec_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= {CNT_W{1'b0}};
    else        count_q <= count_d;
  end

  assign count_out      = count_q;
  assign count_next_out = count_d;
  assign full_out       = (count_q == CNT_W'(MAX_COUNT));
  assign empty_out      = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/fb_scanout_scheduler.sv
// Double-buffered framebuffer scan-out read scheduler with outstanding-read credits.
// Optional macro FB_SCANOUT_STATS_EN builds the saturating dropped-frame-start counter.
module fb_scanout_scheduler
  import fb_sched_pkg::*;
#(
  parameter int unsigned CHUNKS_PER_FRAME = FB_DEFAULT_CHUNKS,
  parameter int unsigned MAX_OUTSTANDING  = 16
) (
  input  logic                 clk_ui,
  input  logic                 rst_ui_n,
  input  logic                 calib_done_in,
  input  logic                 frame_start_in,
  input  logic                 swap_req_in,
  output logic                 ar_valid_out,
  input  logic                 ar_ready_in,
  output logic [FB_ADDR_W-1:0] ar_addr_out,
  input  logic                 r_beat_in,
  output logic                 last_chunk_out,
  output logic                 read_buf_out,
  output logic                 frame_done_out,
  output logic                 busy_out,
  output logic [7:0]           drop_count_out
);

  localparam int unsigned CNT_W = $clog2(CHUNKS_PER_FRAME + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CHUNKS_C = CNT_W'(CHUNKS_PER_FRAME);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(CHUNKS_PER_FRAME - 1);
  localparam logic [OUT_W-1:0] MAX_C    = OUT_W'(MAX_OUTSTANDING);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d, returned_q, returned_d;
  logic             ar_valid_q, ar_valid_d, read_buf_q, read_buf_d;
  logic             swap_pending_q, swap_pending_d;
  logic             frame_done_q, frame_done_d, last_chunk_q, last_chunk_d;
  logic             busy_q, busy_d;
  logic             busy_s, hs_s, beat_ok_s, credit_inc_s;
  logic [OUT_W-1:0] credit_count_s, credit_next_s;
  logic             credit_full_s, credit_empty_s;

  assign busy_s       = (state_q == ISSUE) | (state_q == DRAIN);
  assign hs_s         = ar_valid_q & ar_ready_in;
  assign credit_inc_s = hs_s & ~credit_full_s;
  // Beats outside a frame or with nothing outstanding are stray and dropped
  assign beat_ok_s    = r_beat_in & busy_s & ~credit_empty_s;

  fb_credit_counter #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .CNT_W     (OUT_W)
  ) u_credit (
    .clk            (clk_ui),
    .rst_n          (rst_ui_n),
    .inc            (credit_inc_s),
    .dec            (beat_ok_s),
    .count_out      (credit_count_s),
    .count_next_out (credit_next_s),
    .full_out       (credit_full_s),
    .empty_out      (credit_empty_s)
  );

  // Next-state, frame counters, buffer select and registered output values
  always_comb begin
    state_d        = state_q;
    issued_d       = issued_q;
    returned_d     = returned_q;
    read_buf_d     = read_buf_q;
    swap_pending_d = swap_pending_q | swap_req_in;
    frame_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (calib_done_in) state_d = WAIT_FRAME;
        else               state_d = IDLE;
      end
      WAIT_FRAME: begin
        if (frame_start_in) begin
          state_d    = ISSUE;
          issued_d   = {CNT_W{1'b0}};
          returned_d = {CNT_W{1'b0}};
          // A swap arriving with the start applies to this frame
          if (swap_pending_d) begin
            read_buf_d     = ~read_buf_q;
            swap_pending_d = 1'b0;
          end else begin
            read_buf_d = read_buf_q;
          end
        end else begin
          state_d = WAIT_FRAME;
        end
      end
      ISSUE: begin
        issued_d   = issued_q + CNT_W'(hs_s);
        returned_d = returned_q + CNT_W'(beat_ok_s);
        if (issued_d == CHUNKS_C) state_d = DRAIN;
        else                      state_d = ISSUE;
      end
      DRAIN: begin
        returned_d = returned_q + CNT_W'(beat_ok_s);
        if (returned_d == CHUNKS_C) begin
          frame_done_d = 1'b1;
          state_d      = WAIT_FRAME;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d == ISSUE) | (state_d == DRAIN);
    last_chunk_d = busy_d & (returned_d == LAST_C);
    ar_valid_d   = (state_d == ISSUE) & (issued_d < CHUNKS_C) & (credit_next_s < MAX_C);
  end

  // State and output registers
  always_ff @(posedge clk_ui or negedge rst_ui_n) begin
    if (!rst_ui_n) begin
      state_q        <= IDLE;
      issued_q       <= {CNT_W{1'b0}};
      returned_q     <= {CNT_W{1'b0}};
      ar_valid_q     <= 1'b0;
      read_buf_q     <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_done_q   <= 1'b0;
      last_chunk_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      issued_q       <= issued_d;
      returned_q     <= returned_d;
      ar_valid_q     <= ar_valid_d;
      read_buf_q     <= read_buf_d;
      swap_pending_q <= swap_pending_d;
      frame_done_q   <= frame_done_d;
      last_chunk_q   <= last_chunk_d;
      busy_q         <= busy_d;
    end
  end

  if (CNT_W >= FB_ADDR_W) begin : g_addr_trunc
    assign ar_addr_out = issued_q[FB_ADDR_W-1:0];
  end else begin : g_addr_ext
    assign ar_addr_out = {{(FB_ADDR_W-CNT_W){1'b0}}, issued_q};
  end

  assign ar_valid_out   = ar_valid_q;
  assign read_buf_out   = read_buf_q;
  assign frame_done_out = frame_done_q;
  assign last_chunk_out = last_chunk_q;
  assign busy_out       = busy_q;

`ifdef FB_SCANOUT_STATS_EN
  logic [7:0] drop_q, drop_d;

  // Count frame starts that arrive while a frame is in flight
  always_comb begin
    if (frame_start_in & busy_s) drop_d = sat_inc8(drop_q);
    else                         drop_d = drop_q;
  end

  // Drop counter register
  always_ff @(posedge clk_ui or negedge rst_ui_n) begin
    if (!rst_ui_n) drop_q <= 8'd0;
    else           drop_q <= drop_d;
  end

  assign drop_count_out = drop_q;
`else
  assign drop_count_out = 8'd0;
`endif

endmodule

// File: tb/tb_fb_scanout_scheduler.sv
// Directed bench for fb_scanout_scheduler with 8 chunks per frame and 2 credits.
module tb_fb_scanout_scheduler;

  logic        clk_ui = 1'b0;
  logic        rst_ui_n;
  logic        calib_done_in, frame_start_in, swap_req_in, ar_ready_in, r_beat_in;
  logic        ar_valid_out, last_chunk_out, read_buf_out, frame_done_out, busy_out;
  logic [21:0] ar_addr_out;
  logic [7:0]  drop_count_out;

  int vectors = 0;
  int errors  = 0;

`ifdef FB_SCANOUT_STATS_EN
  localparam logic [31:0] DROP_EXP = 32'd3;
`else
  localparam logic [31:0] DROP_EXP = 32'd0;
`endif

  fb_scanout_scheduler #(
    .CHUNKS_PER_FRAME (8),
    .MAX_OUTSTANDING  (2)
  ) dut (
    .clk_ui         (clk_ui),
    .rst_ui_n       (rst_ui_n),
    .calib_done_in  (calib_done_in),
    .frame_start_in (frame_start_in),
    .swap_req_in    (swap_req_in),
    .ar_valid_out   (ar_valid_out),
    .ar_ready_in    (ar_ready_in),
    .ar_addr_out    (ar_addr_out),
    .r_beat_in      (r_beat_in),
    .last_chunk_out (last_chunk_out),
    .read_buf_out   (read_buf_out),
    .frame_done_out (frame_done_out),
    .busy_out       (busy_out),
    .drop_count_out (drop_count_out)
  );

  always #5 clk_ui = ~clk_ui;

  task automatic step();
    @(posedge clk_ui);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(ar_valid_out), 32'd0);
    check({tag, "_addr"},  32'(ar_addr_out),  32'd0);
    check({tag, "_last"},  32'(last_chunk_out), 32'd0);
    check({tag, "_rbuf"},  32'(read_buf_out), 32'd0);
    check({tag, "_done"},  32'(frame_done_out), 32'd0);
    check({tag, "_busy"},  32'(busy_out), 32'd0);
    check({tag, "_drop"},  32'(drop_count_out), 32'd0);
  endtask

  initial begin
    rst_ui_n = 1'b0; calib_done_in = 1'b0; frame_start_in = 1'b0;
    swap_req_in = 1'b0; ar_ready_in = 1'b0; r_beat_in = 1'b0;
    #23;
    check_all_zero("reset");
    rst_ui_n = 1'b1;

    // Calibration gate: start ignored while uncalibrated
    step();
    frame_start_in = 1'b1; step(); frame_start_in = 1'b0; step();
    check("gate_valid", 32'(ar_valid_out), 32'd0);
    check("gate_busy",  32'(busy_out), 32'd0);
    calib_done_in = 1'b1; step();

    // Frame 1: credit limit, swap request mid-frame, last tag
    frame_start_in = 1'b1; step(); frame_start_in = 1'b0;
    check("f1_valid0", 32'(ar_valid_out), 32'd1);
    check("f1_addr0",  32'(ar_addr_out), 32'd0);
    check("f1_busy",   32'(busy_out), 32'd1);
    ar_ready_in = 1'b1; step();
    check("f1_addr1",  32'(ar_addr_out), 32'd1);
    check("f1_valid1", 32'(ar_valid_out), 32'd1);
    swap_req_in = 1'b1; step(); swap_req_in = 1'b0;
    check("credit_stall_valid", 32'(ar_valid_out), 32'd0);
    check("credit_stall_addr",  32'(ar_addr_out), 32'd2);
    step();
    check("credit_hold_valid", 32'(ar_valid_out), 32'd0);
    check("swap_hold_issue",   32'(read_buf_out), 32'd0);
    r_beat_in = 1'b1; step(); r_beat_in = 1'b0;
    check("credit_return_valid", 32'(ar_valid_out), 32'd1);
    check("credit_return_addr",  32'(ar_addr_out), 32'd2);
    r_beat_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("f1_addr7", 32'(ar_addr_out), 32'd7);
    check("f1_last_early", 32'(last_chunk_out), 32'd0);
    step();
    r_beat_in = 1'b0; ar_ready_in = 1'b0;
    check("drain_valid", 32'(ar_valid_out), 32'd0);
    check("drain_busy",  32'(busy_out), 32'd1);
    check("drain_last",  32'(last_chunk_out), 32'd1);
    check("drain_done",  32'(frame_done_out), 32'd0);
    step();
    check("drain_hold_last", 32'(last_chunk_out), 32'd1);
    check("swap_hold_drain", 32'(read_buf_out), 32'd0);
    r_beat_in = 1'b1; step(); r_beat_in = 1'b0;
    check("f1_done",      32'(frame_done_out), 32'd1);
    check("f1_done_busy", 32'(busy_out), 32'd0);
    check("f1_done_last", 32'(last_chunk_out), 32'd0);
    r_beat_in = 1'b1; step(); r_beat_in = 1'b0;
    check("f1_done_pulse", 32'(frame_done_out), 32'd0);
    check("stray_beat_busy", 32'(busy_out), 32'd0);
    check("swap_hold_wait", 32'(read_buf_out), 32'd0);

    // Frame 2: pending swap applied, three dropped starts
    frame_start_in = 1'b1; step(); frame_start_in = 1'b0;
    check("f2_rbuf",  32'(read_buf_out), 32'd1);
    check("f2_addr0", 32'(ar_addr_out), 32'd0);
    ar_ready_in = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      frame_start_in = 1'b1; step(); frame_start_in = 1'b0; step();
    end
    check("drop_count", 32'(drop_count_out), DROP_EXP);
    check("f2_rbuf_hold", 32'(read_buf_out), 32'd1);
    r_beat_in = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("f2_drain_busy", 32'(busy_out), 32'd1);
    check("f2_drain_last", 32'(last_chunk_out), 32'd1);
    step(); r_beat_in = 1'b0;
    check("f2_done", 32'(frame_done_out), 32'd1);

    // Frame 3: start with simultaneous swap, accepted in the done cycle
    frame_start_in = 1'b1; swap_req_in = 1'b1; step();
    frame_start_in = 1'b0; swap_req_in = 1'b0;
    check("f3_rbuf",  32'(read_buf_out), 32'd0);
    check("f3_busy",  32'(busy_out), 32'd1);
    check("f3_valid", 32'(ar_valid_out), 32'd1);
    r_beat_in = 1'b1;
    for (int i = 0; i < 8; i++) step();
    r_beat_in = 1'b0; ar_ready_in = 1'b0;
    check("underflow_busy", 32'(busy_out), 32'd1);
    check("underflow_last", 32'(last_chunk_out), 32'd1);
    check("underflow_done", 32'(frame_done_out), 32'd0);

    // Asynchronous reset mid-DRAIN, checked before any clock edge
    #3 rst_ui_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #10;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
